// File: rtl/tofpet_readout_arbiter.sv
// Round-robin drain of six TofPet data FIFOs into one 32-bit stream.
// Each grant is emitted as a header word followed by its burst of FIFO data words.
module tofpet_readout_arbiter #(
    parameter int         MAX_BURST = 256,
    parameter logic [7:0] HDR_TAG   = 8'hCA
) (
    input  logic         CK,
    input  logic         RESET,
    input  logic [5:0]   ENABLE,
    input  logic [191:0] FIFO_DATA,
    input  logic [5:0]   FIFO_EMPTY,
    input  logic [5:0]   FIFO_FULL,
    input  logic [65:0]  FIFO_USEDW,
    output logic [5:0]   FIFO_READ,
    output logic [31:0]  OUT_DATA,
    output logic         OUT_VALID,
    input  logic         OUT_READY,
    output logic         OUT_FIRST,
    output logic         OUT_LAST,
    output logic         BUSY,
    output logic [2:0]   GRANT_CH
);

    typedef enum logic [1:0] {IDLE, HEADER, BURST} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        first;
        logic        last;
    } entry_t;

    localparam logic [11:0] MAX_N = 12'(MAX_BURST);

    state_t      state, state_nxt;
    logic [2:0]  ch, last_grant;
    logic [11:0] burst_len, remaining;
    logic        inflight, inflight_last;
    entry_t      buf0, buf1;
    logic [1:0]  occ;

    logic [10:0] usedw_ch [6];
    logic [31:0] data_ch  [6];

    logic        pop, space, rd_en, push;
    entry_t      push_entry;
    logic        grant_found;
    logic [2:0]  grant_idx, idx;
    logic [11:0] raw_len, grant_len;

    for (genvar i = 0; i < 6; i++) begin : g_unpack
        assign usedw_ch[i] = FIFO_USEDW[11*i +: 11];
        assign data_ch[i]  = FIFO_DATA[32*i +: 32];
    end

    // Space counts the word already requested last cycle, so a read is only
    // issued when its data is guaranteed a slot when it returns.
    assign pop   = (occ != 2'd0) && OUT_READY;
    assign space = (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;

    // NOTE: every variable assigned in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 3'd0;
        idx         = 3'd0;
        for (int k = 1; k <= 6; k++) begin
            idx = 3'((int'(last_grant) + k) % 6);
            if (!grant_found && ENABLE[idx] && !FIFO_EMPTY[idx]) begin
                grant_found = 1'b1;
                grant_idx   = idx;
            end
        end
    end

    // An 11-bit USEDW wraps to zero when full; a non-empty FIFO reporting zero holds one word.
    always_comb begin
        raw_len = {1'b0, usedw_ch[grant_idx]};
        if (FIFO_FULL[grant_idx])
            raw_len = 12'd2048;
        else if (usedw_ch[grant_idx] == 11'd0)
            raw_len = 12'd1;
        grant_len = (raw_len > MAX_N) ? MAX_N : raw_len;
    end

    always_comb begin
        state_nxt  = state;
        rd_en      = 1'b0;
        push       = 1'b0;
        push_entry = '0;
        unique case (state)
            IDLE:   if (grant_found) state_nxt = HEADER;
            HEADER: if (space) state_nxt = BURST;
            BURST: begin
                if (space && !FIFO_EMPTY[ch]) begin
                    rd_en = 1'b1;
                    if (remaining == 12'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (RESET) rd_en = 1'b0;

        // Returning data and a header never coincide: a header is always
        // preceded by an IDLE cycle in which no read was issued.
        if (inflight) begin
            push             = 1'b1;
            push_entry.data  = data_ch[ch];
            push_entry.last  = inflight_last;
        end else if (state == HEADER && space) begin
            push             = 1'b1;
            push_entry.data  = {HDR_TAG, 5'b0, ch, 5'b0, burst_len[10:0]};
            push_entry.first = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CK) begin
        if (RESET) begin
            state         <= IDLE;
            ch            <= 3'd0;
            last_grant    <= 3'd5;
            burst_len     <= 12'd0;
            remaining     <= 12'd0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            occ           <= 2'd0;
            // NOTE: the two buffer entries are reset too, because the head entry
            // drives OUT_DATA directly and must read zero out of reset.
            buf0          <= '0;
            buf1          <= '0;
        end else begin
            state         <= state_nxt;
            inflight      <= rd_en;
            inflight_last <= rd_en && (remaining == 12'd1);
            if (state == IDLE && grant_found) begin
                ch         <= grant_idx;
                last_grant <= grant_idx;
                burst_len  <= grant_len;
            end
            if (state == HEADER && space) remaining <= burst_len;
            if (rd_en) remaining <= remaining - 12'd1;

            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= push_entry;
                    else             buf1 <= push_entry;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= push_entry;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign FIFO_READ = rd_en ? (6'b000001 << ch) : 6'b000000;
    assign OUT_VALID = (occ != 2'd0);
    assign OUT_DATA  = buf0.data;
    assign OUT_FIRST = OUT_VALID && buf0.first;
    assign OUT_LAST  = OUT_VALID && buf0.last;
    assign BUSY      = (state != IDLE) || (occ != 2'd0) || inflight;
    assign GRANT_CH  = ch;

endmodule
